entity_tile_renderer: RTL and testbench
=======================================

// Module: entity_tile_renderer
// PURPOSE
// - Pixel-colour stage between the VGA sync generator and the top-level RGB output register.
// - Takes the beam position (counter_H/counter_V) and a table of up to NUM_ENTITIES entities.
// - Each entity is {ID[13:10], orientation[9:8], tile location[7:0]}.
// - Produces a 1-bit colour per pixel from 8x8 sprites scaled x4 onto a 16x15 tile grid.
// - Snapshots the entity table once per frame so sprites never tear mid-frame.
// PARAMETERS
// - NUM_ENTITIES  4    number of entity slots (1..9)
// - H_ACTIVE      640  visible pixels per line
// - V_ACTIVE      480  visible lines per frame
// - GRID_X0       64   first pixel column of the grid; grid spans [64,575]
// - TILE_SHIFT    5    log2 tile size in pixels (32); sprite pixel = 4x4 screen pixels
// PORTS
// - clk           in   1                 pixel clock
// - rst_n         in   1                 synchronous, active-low reset
// - entity_flat   in   14*NUM_ENTITIES   slot k at bits [14k+13:14k]; slot 0 = highest priority
// - counter_H     in   10                current beam x from the sync generator
// - counter_V     in   10                current beam y from the sync generator
// - colour        out  1                 pixel value, 2 cycles after its counters
// - frame_latched out  1                 1-cycle pulse when the entity table is snapshotted
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge):
//   - colour=0, frame_latched=0, both pipeline stages cleared.
//   - All snapshot slots get ID=4'hF (unused); orientation and location = 0.
// - Snapshot:
//   - Taken on the cycle where counter_V==V_ACTIVE && counter_H==0 (start of vblank).
//   - entity_flat is copied into the internal table; frame_latched=1 on the following cycle.
//   - entity_flat changes at any other time have no effect until the next snapshot.
// - Grid mapping:
//   - gx = counter_H - GRID_X0 (10-bit unsigned); gy = counter_V.
//   - The pixel is in the grid iff counter_H in [64,575] and counter_V < 480.
//   - tile_col = gx[8:5], tile_row = gy[8:5]; row 15 is unreachable (480/32 = 15).
//   - spr_c = gx[4:2], spr_r = gy[4:2].
//   - Entity match: location[7:4]==tile_row && location[3:0]==tile_col && ID!=4'hF.
// - Priority:
//   - Lowest-index matching slot owns the tile.
//   - A 0 sprite bit shows background 0; lower-priority slots never show through.
// - Orientation (source row/col fetched from the ROM for display r,c):
//   - 00 up:    (r, c)
//   - 01 right: (7-c, r)
//   - 10 down:  (7-r, 7-c)
//   - 11 left:  (c, 7-r)
// - Pipeline:
//   - S1 registers in_grid, hit, winning ID, orientation, spr_r and spr_c.
//   - S2 registers colour = in_grid & hit & rom_bit.
//   - Out of grid or no hit gives colour=0.
//   - Latency is exactly 2 clk; the top delays hsync, vsync and display_on by 2 to align.
// - Simultaneous events:
//   - Reset has priority over a snapshot in the same cycle.
//   - A snapshot cycle still renders the pixel in flight, using the old table.
// - Reset mid-frame: output is 0 until the pipeline refills.
//   - The table stays all-unused until the next vblank snapshot.
// STRUCTURE
// - Package stt8_gfx_pkg holds:
//   - ENTITY_W=14, ID_UNUSED=4'hF, the orientation constants ORI_UP/RIGHT/DOWN/LEFT.
//   - Grid constants GRID_COLS=16, GRID_ROWS=15.
//   - An entity_t field-slice helper.
// - Sub-module sprite_rom:
//   - Combinational; inputs id[3:0], row[2:0], col[2:0]; output pixel bit.
//   - IDs 0..14 each define one 8x8 bitmap; ID 15 returns 0.
// - Top body: snapshot registers, match/priority logic, orientation transform, 2-stage pipeline.
// TESTING
// - Reset: hold rst_n=0 for 3 clk with a random entity_flat -> colour=0 and frame_latched=0.
//   - After release, sweep a full frame before any snapshot -> colour=0 everywhere.
// - Snapshot:
//   - Slot0 = {ID 1, ori 00, loc 8'h00}; drive V=480, H=0 -> frame_latched pulses 1 cycle.
//   - In the next frame, pixels H 64..95 / V 0..31 equal sprite 1 row/col >>2.
//   - Pixels at H=63 and H=96 give colour 0.
// - Latency and orientation: ID 2 at loc 8'h35 (row 3, col 5 -> H 224..255, V 96..127).
//   - For each ori 00/01/10/11, colour at H=228, V=96 (r=0, c=1) two cycles later
//     equals ROM bits (0,1), (6,0), (7,6), (1,7) respectively.
// - Priority: slot0 = ID 3 and slot1 = ID 4, both at loc 8'h22.
//   - The tile shows only ID 3, including pixels where ID 3's bit=0 and ID 4's bit=1.
//   - Set slot0 ID=4'hF -> after the next snapshot the tile shows ID 4.
// - Tear-free and boundary:
//   - Change entity_flat at V=200 -> no change before V=480; the change appears the next frame.
//   - loc 8'hF0 (row 15) is never drawn.
//   - loc 8'h0F is drawn at H 544..575.

Source files
------------

// File: rtl/stt8_gfx_pkg.sv
// Shared graphics definitions for the STT8 tile renderer: entity layout,
// orientation codes and grid geometry.
package stt8_gfx_pkg;

    localparam int ENTITY_W = 14;
    localparam logic [3:0] ID_UNUSED = 4'hF;

    localparam logic [1:0] ORI_UP    = 2'b00;
    localparam logic [1:0] ORI_RIGHT = 2'b01;
    localparam logic [1:0] ORI_DOWN  = 2'b10;
    localparam logic [1:0] ORI_LEFT  = 2'b11;

    localparam int GRID_COLS = 16;
    localparam int GRID_ROWS = 15;

    // Field order matches the flat bus: {ID[13:10], orientation[9:8], location[7:0]}
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] ori;
        logic [7:0] loc;
    } entity_t;

    function automatic entity_t entity_slice(input logic [ENTITY_W-1:0] raw);
        return entity_t'(raw);
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Combinational 8x8 sprite bitmaps; row 0 is the top, col 0 is the MSB of each row byte.
// ID 15 is the unused slot and always reads 0.
module sprite_rom (
    input  logic [3:0] id,
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       pixel
);

    logic [63:0] bmp;

    always_comb begin
        bmp = '0;
        case (id)
            4'd0:    bmp = 64'h3C42_8181_8181_423C;
            4'd1:    bmp = 64'h183C_7EFF_1818_1818;
            4'd2:    bmp = 64'hF880_80F0_8080_8181;
            4'd3:    bmp = 64'hAA55_AA55_AA55_AA55;
            4'd4:    bmp = 64'h55AA_55AA_55AA_55AA;
            4'd5:    bmp = 64'hFF81_8181_8181_81FF;
            4'd6:    bmp = 64'h0066_6600_0081_423C;
            4'd7:    bmp = 64'h0102_0408_1020_4080;
            4'd8:    bmp = 64'h8040_2010_0804_0201;
            4'd9:    bmp = 64'hFFFF_0000_FFFF_0000;
            4'd10:   bmp = 64'hF0F0_F0F0_0F0F_0F0F;
            4'd11:   bmp = 64'h1038_7CFE_7C38_1000;
            4'd12:   bmp = 64'hE7E7_E700_00E7_E7E7;
            4'd13:   bmp = 64'h3C66_C3C3_FFC3_C3C3;
            4'd14:   bmp = 64'hFE82_BAAA_BA82_FE00;
            default: bmp = '0;
        endcase
    end

    // Bit 63 is (row 0, col 0), so the index is the complement of {row, col}
    assign pixel = bmp[~{row, col}];

endmodule

// File: rtl/entity_tile_renderer.sv
// Pixel-colour stage: maps the beam onto a 16x15 tile grid, picks the highest-priority
// entity on the tile and emits its oriented, x4-scaled sprite bit two clocks later.
module entity_tile_renderer
    import stt8_gfx_pkg::*;
#(
    parameter int NUM_ENTITIES = 4,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int GRID_X0      = 64,
    parameter int TILE_SHIFT   = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ENTITY_W*NUM_ENTITIES-1:0] entity_flat,
    input  logic [9:0]                       counter_H,
    input  logic [9:0]                       counter_V,
    output logic                             colour,
    output logic                             frame_latched
);

    localparam int GRID_X1 = GRID_X0 + (GRID_COLS << TILE_SHIFT) - 1;

    entity_t tbl [NUM_ENTITIES];
    logic    snap;

    assign snap = (counter_V == 10'(V_ACTIVE)) && (counter_H == 10'd0);

    // Table only changes at start of vblank so a frame never mixes two entity sets
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_latched <= 1'b0;
            for (int k = 0; k < NUM_ENTITIES; k++)
                tbl[k] <= '{id: ID_UNUSED, ori: ORI_UP, loc: 8'h00};
        end else begin
            frame_latched <= snap;
            if (snap)
                for (int k = 0; k < NUM_ENTITIES; k++)
                    tbl[k] <= entity_slice(entity_flat[k*ENTITY_W +: ENTITY_W]);
        end
    end

    logic [9:0] gx;
    logic       in_grid;
    logic [3:0] tile_col, tile_row;
    logic [2:0] spr_r, spr_c;

    assign gx       = counter_H - 10'(GRID_X0);
    assign in_grid  = (counter_H >= 10'(GRID_X0)) && (counter_H <= 10'(GRID_X1)) &&
                      (counter_H < 10'(H_ACTIVE)) && (counter_V < 10'(V_ACTIVE));
    assign tile_col = 4'(gx >> TILE_SHIFT);
    assign tile_row = 4'(counter_V >> TILE_SHIFT);
    assign spr_c    = 3'(gx >> (TILE_SHIFT - 3));
    assign spr_r    = 3'(counter_V >> (TILE_SHIFT - 3));

    logic [NUM_ENTITIES-1:0] match;

    for (genvar k = 0; k < NUM_ENTITIES; k++) begin : g_match
        assign match[k] = (tbl[k].id != ID_UNUSED) && (tbl[k].loc == {tile_row, tile_col});
    end

    logic       hit;
    logic [3:0] win_id;
    logic [1:0] win_ori;

    // Scan from the lowest priority upward so the lowest matching index wins
    always_comb begin
        hit     = 1'b0;
        win_id  = ID_UNUSED;
        win_ori = ORI_UP;
        for (int k = NUM_ENTITIES - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit     = 1'b1;
                win_id  = tbl[k].id;
                win_ori = tbl[k].ori;
            end
        end
    end

    logic       s1_in_grid, s1_hit;
    logic [3:0] s1_id;
    logic [1:0] s1_ori;
    logic [2:0] s1_r, s1_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_in_grid <= 1'b0;
            s1_hit     <= 1'b0;
            s1_id      <= ID_UNUSED;
            s1_ori     <= ORI_UP;
            s1_r       <= '0;
            s1_c       <= '0;
        end else begin
            s1_in_grid <= in_grid;
            s1_hit     <= hit;
            s1_id      <= win_id;
            s1_ori     <= win_ori;
            s1_r       <= spr_r;
            s1_c       <= spr_c;
        end
    end

    // Display (r,c) -> source ROM (row,col); 7-x is just bitwise inversion on 3 bits
    logic [2:0] src_r, src_c;

    always_comb begin
        src_r = s1_r;
        src_c = s1_c;
        case (s1_ori)
            ORI_UP:    begin src_r = s1_r;  src_c = s1_c;  end
            ORI_RIGHT: begin src_r = ~s1_c; src_c = s1_r;  end
            ORI_DOWN:  begin src_r = ~s1_r; src_c = ~s1_c; end
            ORI_LEFT:  begin src_r = s1_c;  src_c = ~s1_r; end
            default:   begin src_r = s1_r;  src_c = s1_c;  end
        endcase
    end

    logic rom_bit;

    sprite_rom u_rom (
        .id    (s1_id),
        .row   (src_r),
        .col   (src_c),
        .pixel (rom_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) colour <= 1'b0;
        else        colour <= s1_in_grid & s1_hit & rom_bit;
    end

endmodule

// File: tb/tb_entity_tile_renderer.sv
// Scoreboard bench for entity_tile_renderer: stimulus pushes expected pixels into a queue,
// a monitor pops and compares them as the 2-cycle pipeline delivers them.
module tb_entity_tile_renderer;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [14*N-1:0] entity_flat = '1;
    logic [9:0]      counter_H = '0;
    logic [9:0]      counter_V = '0;
    logic            colour;
    logic            frame_latched;

    entity_tile_renderer #(.NUM_ENTITIES(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .entity_flat   (entity_flat),
        .counter_H     (counter_H),
        .counter_V     (counter_V),
        .colour        (colour),
        .frame_latched (frame_latched)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic col;
        int   h;
        int   v;
    } exp_t;

    exp_t        exp_q[$];
    logic [13:0] tb_tab [N];
    logic [63:0] tb_bmp [16];
    int          n_chk = 0;
    int          n_fail = 0;

    logic chk_now = 1'b0, chk_d1 = 1'b0, chk_d2 = 1'b0;
    logic fl_en = 1'b0, fl_exp = 1'b0;

    initial begin
        tb_bmp[0]  = 64'h3C42_8181_8181_423C;
        tb_bmp[1]  = 64'h183C_7EFF_1818_1818;
        tb_bmp[2]  = 64'hF880_80F0_8080_8181;
        tb_bmp[3]  = 64'hAA55_AA55_AA55_AA55;
        tb_bmp[4]  = 64'h55AA_55AA_55AA_55AA;
        tb_bmp[5]  = 64'hFF81_8181_8181_81FF;
        tb_bmp[6]  = 64'h0066_6600_0081_423C;
        tb_bmp[7]  = 64'h0102_0408_1020_4080;
        tb_bmp[8]  = 64'h8040_2010_0804_0201;
        tb_bmp[9]  = 64'hFFFF_0000_FFFF_0000;
        tb_bmp[10] = 64'hF0F0_F0F0_0F0F_0F0F;
        tb_bmp[11] = 64'h1038_7CFE_7C38_1000;
        tb_bmp[12] = 64'hE7E7_E700_00E7_E7E7;
        tb_bmp[13] = 64'h3C66_C3C3_FFC3_C3C3;
        tb_bmp[14] = 64'hFE82_BAAA_BA82_FE00;
        tb_bmp[15] = 64'h0;
        for (int k = 0; k < N; k++) tb_tab[k] = 14'h3C00;
    end

    function automatic logic model_col(input int h, input int v);
        int gx, tr, tc, r, c, sr, sc;
        logic [13:0] e;
        if (!(h >= 64 && h <= 575 && v < 480)) return 1'b0;
        gx = h - 64;
        tc = (gx >> 5) & 15;
        tr = (v >> 5) & 15;
        c  = (gx >> 2) & 7;
        r  = (v >> 2) & 7;
        for (int k = 0; k < N; k++) begin
            e = tb_tab[k];
            if (e[13:10] != 4'hF && e[7:4] == tr[3:0] && e[3:0] == tc[3:0]) begin
                case (e[9:8])
                    2'b00:   begin sr = r;     sc = c;     end
                    2'b01:   begin sr = 7 - c; sc = r;     end
                    2'b10:   begin sr = 7 - r; sc = 7 - c; end
                    default: begin sr = c;     sc = 7 - r; end
                endcase
                return tb_bmp[e[13:10]][63 - (8*sr + sc)];
            end
        end
        return 1'b0;
    endfunction

    // One pixel per call; use_exp selects a hand-computed value over the model
    task automatic drive(input int h, input int v, input logic r, input logic use_exp,
                         input logic expv);
        exp_t e;
        @(negedge clk);
        rst_n     = r;
        counter_H = 10'(h);
        counter_V = 10'(v);
        e.h   = h;
        e.v   = v;
        e.col = !r ? 1'b0 : (use_exp ? expv : model_col(h, v));
        exp_q.push_back(e);
        chk_now = 1'b1;
        if (!r)
            for (int k = 0; k < N; k++) tb_tab[k] = 14'h3C00;
        else if (h == 0 && v == 480)
            for (int k = 0; k < N; k++) tb_tab[k] = entity_flat[14*k +: 14];
    endtask

    task automatic px(input int h, input int v);
        drive(h, v, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pxe(input int h, input int v, input logic expv);
        drive(h, v, 1'b1, 1'b1, expv);
    endtask

    task automatic set_slot(input int k, input logic [3:0] id, input logic [1:0] ori,
                            input logic [7:0] loc);
        entity_flat[14*k +: 14] = {id, ori, loc};
    endtask

    task automatic tile(input int h0, input int v0);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                px(h0 + 4*c + (r % 4), v0 + 4*r + (c % 4));
        for (int r = 0; r < 8; r++) begin
            px(h0 - 1, v0 + 4*r);
            px(h0 + 32, v0 + 4*r);
        end
    endtask

    task automatic snapshot();
        px(0, 480);
        px(700, 500);
    endtask

    always @(posedge clk) begin
        chk_d1 <= chk_now;
        chk_d2 <= chk_d1;
        fl_en  <= chk_now;
        fl_exp <= rst_n && counter_V == 10'd480 && counter_H == 10'd0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_d2) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: colour=%b with no expected entry", colour);
            end else begin
                e = exp_q.pop_front();
                if (colour !== e.col) begin
                    n_fail++;
                    $display("FAIL colour H=%0d V=%0d: got %b expected %b", e.h, e.v, colour, e.col);
                end
            end
        end
        if (fl_en) begin
            n_chk++;
            if (frame_latched !== fl_exp) begin
                n_fail++;
                $display("FAIL frame_latched: got %b expected %b", frame_latched, fl_exp);
            end
        end
    end

    initial begin
        // Reset with junk on the table bus, including a would-be snapshot cycle
        entity_flat = {$urandom, $urandom};
        drive(100, 10, 1'b0, 1'b0, 1'b0);
        drive(0, 480, 1'b0, 1'b0, 1'b0);
        drive(80, 0, 1'b0, 1'b0, 1'b0);

        // No snapshot yet: whole visible frame is blank
        for (int v = 0; v < 480; v += 16)
            for (int h = 0; h < 640; h += 16)
                pxe(h + 1, v + 2, 1'b0);

        // Sprite 1 upright at tile (0,0)
        entity_flat = '1;
        set_slot(0, 4'd1, 2'b00, 8'h00);
        snapshot();
        pxe(64 + 12, 0, 1'b1);
        pxe(64, 0, 1'b0);
        pxe(63, 12, 1'b0);
        pxe(96, 12, 1'b0);
        tile(64, 0);

        // Sprite 2 at tile row 3 col 5 through all orientations
        for (int o = 0; o < 4; o++) begin
            set_slot(0, 4'd2, 2'(o), 8'h35);
            snapshot();
            pxe(228, 96, (o < 2) ? 1'b1 : 1'b0);
            tile(224, 96);
        end

        // Priority: slot0 ID3 hides slot1 ID4 on the same tile
        entity_flat = '1;
        set_slot(0, 4'd3, 2'b00, 8'h22);
        set_slot(1, 4'd4, 2'b00, 8'h22);
        snapshot();
        pxe(132, 64, 1'b0);
        pxe(128, 64, 1'b1);
        tile(128, 64);
        set_slot(0, 4'hF, 2'b00, 8'h22);
        snapshot();
        pxe(132, 64, 1'b1);
        pxe(128, 64, 1'b0);
        tile(128, 64);

        // Tear-free: a mid-frame bus change waits for the next vblank
        entity_flat = '1;
        set_slot(0, 4'd5, 2'b00, 8'h11);
        snapshot();
        pxe(101, 38, 1'b0);
        px(300, 200);
        set_slot(0, 4'd6, 2'b00, 8'h11);
        set_slot(1, 4'd7, 2'b00, 8'hF0);
        set_slot(2, 4'd8, 2'b00, 8'h0F);
        pxe(101, 38, 1'b0);
        pxe(96, 32, 1'b1);
        tile(96, 32);
        px(544, 0);
        snapshot();
        pxe(101, 38, 1'b1);
        pxe(96, 32, 1'b0);
        tile(96, 32);
        pxe(544, 0, 1'b1);
        pxe(575, 28, 1'b1);
        pxe(576, 28, 1'b0);
        tile(544, 0);
        for (int h = 64; h < 576; h += 8)
            pxe(h, 480 + (h % 32), 1'b0);

        px(700, 500);
        px(700, 500);
        px(700, 500);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
